// File: rtl/rv_pkg.sv
// Shared core types and widths for the fetch path.
// Prefetch buffer FSM state encodings live here too.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int PF_DEPTH = 4;

    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT,
        C_RESP
    } core_state_t;

    typedef enum logic {
        M_IDLE,
        M_BUSY
    } mem_state_t;

endpackage

// File: rtl/instr_prefetch_buf_fifo.sv
// Circular word buffer for the instruction prefetcher.
// Head entry is always visible on head_data while count is non-zero.
module prefetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = PF_DEPTH
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [XLEN-1:0]         wdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic [XLEN-1:0]         head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    // Storage write; entries need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; flush empties the ring.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_buf.sv
// Sequential instruction prefetcher between core fetch port and SPI flash.
// Streams words ahead of the core; jumps and fence.i restart the stream.
module instr_prefetch_buf
    import rv_pkg::*;
#(
    parameter int              DEPTH       = PF_DEPTH,
    parameter logic [XLEN-1:0] FLASH_BYTES = XLEN'(1 << 24)
) (
    input  logic            clk,
    input  logic            arstn,
    input  logic            flush_i,
    input  logic            core_req_i,
    input  logic [XLEN-1:0] core_addr_i,
    output logic            core_rvalid_o,
    output logic [XLEN-1:0] core_rdata_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    core_state_t cstate, cstate_n;
    mem_state_t  mstate, mstate_n;

    logic [XLEN-1:0] head_addr;
    logic [XLEN-1:0] fetch_addr;
    logic            stream_active;
    logic            discard;

    logic [CW-1:0]   count;
    logic [XLEN-1:0] head_data;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] pop_data;
    logic            addr_match;
    logic            mem_done;
    logic            word_ok;
    logic            pop;
    logic            miss;
    logic            bypass;
    logic            issue;
    logic            fifo_push;
    logic            unused_addr_lsb;

    assign req_addr        = {core_addr_i[XLEN-1:2], 2'b00};
    assign unused_addr_lsb = ^core_addr_i[1:0];
    assign addr_match      = (req_addr == head_addr);
    assign mem_done        = (mstate == M_BUSY) && mem_rvalid_i;
    assign word_ok         = mem_done && !discard;
    assign fifo_push       = word_ok && !bypass && !flush_i && !miss;
    assign core_rvalid_o   = (cstate == C_RESP);

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arstn     (arstn),
        .flush     (flush_i | miss),
        .push      (fifo_push),
        .pop       (pop),
        .wdata     (mem_rdata_i),
        .count     (count),
        .head_data (head_data)
    );

    // Core-side next state: hit, wait on the stream, or restart it.
    always_comb begin
        cstate_n = cstate;
        pop      = 1'b0;
        miss     = 1'b0;
        bypass   = 1'b0;
        pop_data = head_data;
        unique case (cstate)
            C_IDLE: begin
                if (!flush_i && core_req_i) begin
                    if (addr_match && count != '0) begin
                        pop      = 1'b1;
                        cstate_n = C_RESP;
                    end else if (addr_match && stream_active) begin
                        cstate_n = C_WAIT;
                    end else begin
                        miss     = 1'b1;
                        cstate_n = C_WAIT;
                    end
                end
            end
            C_WAIT: begin
                if (flush_i) begin
                    cstate_n = C_IDLE;
                end else if (count != '0) begin
                    pop      = 1'b1;
                    cstate_n = C_RESP;
                end else if (word_ok) begin
                    bypass   = 1'b1;
                    pop_data = mem_rdata_i;
                    cstate_n = C_RESP;
                end
            end
            C_RESP: begin
                cstate_n = C_IDLE;
            end
            default: begin
                cstate_n = C_IDLE;
            end
        endcase
    end

    // Flash-side next state: one outstanding word at a time.
    always_comb begin
        mstate_n = mstate;
        issue    = 1'b0;
        unique case (mstate)
            M_IDLE: begin
                if (stream_active && count < CW'(DEPTH) &&
                    fetch_addr < FLASH_BYTES && !flush_i && !miss) begin
                    issue    = 1'b1;
                    mstate_n = M_BUSY;
                end
            end
            M_BUSY: begin
                if (mem_rvalid_i) begin
                    mstate_n = M_IDLE;
                end
            end
            default: begin
                mstate_n = M_IDLE;
            end
        endcase
    end

    // Core-side registers: state, returned word, head address.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cstate       <= C_IDLE;
            core_rdata_o <= '0;
            head_addr    <= '0;
        end else begin
            cstate <= cstate_n;
            if (pop || bypass) begin
                core_rdata_o <= pop_data;
            end
            if (miss) begin
                head_addr <= req_addr;
            end else if (pop || bypass) begin
                head_addr <= head_addr + XLEN'(4);
            end
        end
    end

    // Flash-side registers: request handshake, stream position, discard.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            mstate        <= M_IDLE;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            fetch_addr    <= '0;
            stream_active <= 1'b0;
            discard       <= 1'b0;
        end else begin
            mstate <= mstate_n;
            if (issue) begin
                mem_req_o  <= 1'b1;
                mem_addr_o <= fetch_addr;
            end else if (mem_done) begin
                mem_req_o <= 1'b0;
            end
            if (miss) begin
                fetch_addr <= req_addr;
            end else if (word_ok) begin
                fetch_addr <= fetch_addr + XLEN'(4);
            end
            if (flush_i) begin
                stream_active <= 1'b0;
            end else if (miss) begin
                stream_active <= 1'b1;
            end
            if ((flush_i || miss) && mstate == M_BUSY && !mem_rvalid_i) begin
                discard <= 1'b1;
            end else if (mem_done) begin
                discard <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Directed bench for instr_prefetch_buf with a fixed-latency flash model.
// Second instance runs with a 32-byte flash to cover the end-of-flash gate.
module tb_instr_prefetch_buf;
    import rv_pkg::*;

    localparam int LAT = 40;
    localparam logic [31:0] XM = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        flush = 1'b0;
    logic        core_req = 1'b0;
    logic [31:0] core_addr = '0;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        core_req2 = 1'b0;
    logic [31:0] core_addr2 = '0;
    logic        core_rvalid2;
    logic [31:0] core_rdata2;
    logic        mem_req2;
    logic [31:0] mem_addr2;
    logic        mem_rvalid2 = 1'b0;
    logic [31:0] mem_rdata2 = '0;

    int          n_run = 0;
    int          n_fail = 0;
    logic [31:0] iss_q[$];
    logic [31:0] iss2_q[$];
    logic [31:0] last_core = '0;
    int          ahead_viol = 0;

    always #5 clk = ~clk;

    instr_prefetch_buf #(
        .DEPTH (4)
    ) u_dut (
        .clk           (clk),
        .arstn         (arstn),
        .flush_i       (flush),
        .core_req_i    (core_req),
        .core_addr_i   (core_addr),
        .core_rvalid_o (core_rvalid),
        .core_rdata_o  (core_rdata),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata)
    );

    instr_prefetch_buf #(
        .DEPTH       (4),
        .FLASH_BYTES (32'h20)
    ) u_dut2 (
        .clk           (clk),
        .arstn         (arstn),
        .flush_i       (1'b0),
        .core_req_i    (core_req2),
        .core_addr_i   (core_addr2),
        .core_rvalid_o (core_rvalid2),
        .core_rdata_o  (core_rdata2),
        .mem_req_o     (mem_req2),
        .mem_addr_o    (mem_addr2),
        .mem_rvalid_i  (mem_rvalid2),
        .mem_rdata_i   (mem_rdata2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flash model for the main instance; aborts silently on reset.
    initial begin
        logic [31:0] a;
        bit          abort;
        forever begin
            @(posedge clk); #1;
            if (arstn && mem_req) begin
                a = mem_addr;
                iss_q.push_back(a);
                if (a > last_core + 32'd16) ahead_viol++;
                abort = 0;
                for (int i = 1; i < LAT; i++) begin
                    @(posedge clk); #1;
                    if (!arstn) begin
                        abort = 1;
                        break;
                    end
                end
                if (!abort) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = a ^ XM;
                    @(posedge clk); #1;
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    // Flash model for the small-flash instance.
    initial begin
        logic [31:0] a;
        forever begin
            @(posedge clk); #1;
            if (arstn && mem_req2) begin
                a = mem_addr2;
                iss2_q.push_back(a);
                for (int i = 1; i < LAT; i++) begin
                    @(posedge clk); #1;
                end
                mem_rvalid2 = 1'b1;
                mem_rdata2  = a ^ XM;
                @(posedge clk); #1;
                mem_rvalid2 = 1'b0;
            end
        end
    end

    // lat counts cycles from the cycle req rises to the rvalid cycle.
    task automatic fetch(input logic [31:0] a, output logic [31:0] d,
                         output int lat);
        bit got;
        @(posedge clk); #1;
        core_req  = 1'b1;
        core_addr = a;
        last_core = a;
        lat = 1;
        d   = '0;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            lat++;
            if (core_rvalid) begin
                d   = core_rdata;
                got = 1;
                break;
            end
        end
        core_req = 1'b0;
        if (!got) check("fetch_timeout", 32'd0, 32'd1);
    endtask

    task automatic fetch2(input logic [31:0] a, output logic [31:0] d);
        bit got;
        @(posedge clk); #1;
        core_req2  = 1'b1;
        core_addr2 = a;
        d   = '0;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (core_rvalid2) begin
                d   = core_rdata2;
                got = 1;
                break;
            end
        end
        core_req2 = 1'b0;
        if (!got) check("fetch2_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          lat;
        int          base;
        int          bad;
        logic [31:0] a;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", {31'd0, core_rvalid}, 32'd0);
        check("rst_rdata", core_rdata, 32'd0);
        check("rst_mreq", {31'd0, mem_req}, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mreq2", {31'd0, mem_req2}, 32'd0);
        arstn = 1'b1;

        // Cold miss at 0x0, then let the buffer fill
        fetch(32'h0, d, lat);
        check("cold_data", d, 32'hA5A5_0000);
        check("cold_lat", 32'(lat >= 42 && lat <= 46), 32'd1);
        repeat (250) @(posedge clk);
        check("fill_cnt", 32'(iss_q.size()), 32'd5);
        check("fill_last", iss_q[$], 32'h10);

        // Sequential stream 0x4..0x3C; first four are buffered hits
        for (int i = 1; i < 16; i++) begin
            a = 32'(i * 4);
            fetch(a, d, lat);
            check("seq_data", d, a ^ XM);
            if (i <= 4) check("hit_lat", 32'(lat), 32'd2);
        end
        repeat (250) @(posedge clk);
        bad = 0;
        foreach (iss_q[i]) if (iss_q[i] != 32'(i * 4)) bad++;
        check("seq_order", 32'(bad), 32'd0);
        check("seq_cnt", 32'(iss_q.size()), 32'd20);

        // Stall after a restart at 0x0: exactly DEPTH prefetches
        base = iss_q.size();
        fetch(32'h0, d, lat);
        check("stall_data", d, 32'hA5A5_0000);
        repeat (250) @(posedge clk);
        check("stall_cnt", 32'(iss_q.size() - base), 32'd5);
        check("stall_first", iss_q[base + 1], 32'h4);
        check("stall_last", iss_q[$], 32'h10);
        check("stall_idle", {31'd0, mem_req}, 32'd0);

        // fence.i on a full buffer, then 0x4 must miss
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        base = iss_q.size();
        fetch(32'h4, d, lat);
        check("flush_data", d, 32'hA5A5_0004);
        check("flush_miss", 32'(lat >= 42 && lat <= 46), 32'd1);
        check("flush_req", iss_q[base], 32'h4);

        // Jump while 0x8 is in flight
        fetch(32'h200, d, lat);
        check("jump_data", d, 32'hA5A5_0200);
        check("jump_inflt", iss_q[base + 1], 32'h8);
        check("jump_req", iss_q[base + 2], 32'h200);
        fetch(32'h204, d, lat);
        check("jump_next", d, 32'hA5A5_0204);

        // Reset while a flash request is outstanding
        bad = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                bad = 0;
                break;
            end
        end
        check("busy_seen", 32'(bad), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        arstn = 1'b0;
        @(posedge clk); #1;
        check("arst_mreq", {31'd0, mem_req}, 32'd0);
        check("arst_maddr", mem_addr, 32'd0);
        check("arst_rdata", core_rdata, 32'd0);
        check("arst_rvalid", {31'd0, core_rvalid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        base = iss_q.size();
        fetch(32'h0, d, lat);
        check("post_data", d, 32'hA5A5_0000);
        check("post_lat", 32'(lat >= 42 && lat <= 46), 32'd1);
        check("post_req", iss_q[base], 32'h0);

        // End-of-flash gate on the 32-byte instance
        for (int i = 4; i < 8; i++) begin
            a = 32'(i * 4);
            fetch2(a, d);
            check("flash_data", d, a ^ XM);
        end
        repeat (150) @(posedge clk);
        bad = 0;
        foreach (iss2_q[i]) if (iss2_q[i] >= 32'h20) bad++;
        check("flash_bound", 32'(bad), 32'd0);
        check("flash_cnt", 32'(iss2_q.size()), 32'd4);
        check("flash_idle", {31'd0, mem_req2}, 32'd0);

        check("ahead", 32'(ahead_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
